battle_front_calc: RTL and testbench

- Game-tick combat resolver that sits directly upstream of every player unit and enemy instance.
- Scans all unit and enemy positions, damage outputs and alive flags, then computes the frontmost enemy and the frontmost unit.
- Computes aggregate damage in each direction and whether the spawn lane is clear.
- Broadcasts these results with one-cycle damageSCEN and moveSCEN strobes once per game tick.

---
 rtl/battle_front_calc.sv | 176 +++++++++++++++++
 tb/tb_battle_front_calc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/battle_front_calc.sv
// Per-tick combat resolver: scans one unit slot and one enemy slot per cycle, then
// publishes fronts, saturated damage totals and spawn-lane status with SCEN strobes.
module battle_front_calc #(
  parameter int          NUM_UNITS   = 4,
  parameter int          NUM_ENEMIES = 4,
  parameter logic [23:0] TICK_CYCLES = 24'd1_000_000,
  parameter logic [8:0]  SPAWN_GAP   = 9'd32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic [9*NUM_UNITS-1:0]   unitPos,
  input  logic [8*NUM_UNITS-1:0]   unitDamage,
  input  logic [NUM_UNITS-1:0]     unitDead,
  input  logic [9*NUM_ENEMIES-1:0] enemyPos,
  input  logic [8*NUM_ENEMIES-1:0] enemyDamage,
  input  logic [NUM_ENEMIES-1:0]   enemyDead,
  output logic [8:0]               enemyFront,
  output logic [8:0]               unitFront,
  output logic [7:0]               damageToUnits,
  output logic [7:0]               damageToEnemies,
  output logic                     damageSCEN,
  output logic                     moveSCEN,
  output logic                     canSpawn,
  output logic                     busy
);

  localparam int          SCAN_LEN    = (NUM_UNITS > NUM_ENEMIES) ? NUM_UNITS : NUM_ENEMIES;
  localparam logic [2:0]  LAST_IDX    = 3'(SCAN_LEN - 1);
  localparam logic [23:0] TICK_LAST   = TICK_CYCLES - 24'd1;
  localparam logic [8:0]  SPAWN_LIMIT = 9'h1FF - SPAWN_GAP;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, MOVE} state_t;

  state_t      state_reg;
  logic [23:0] tick_count_reg;
  logic [2:0]  idx_reg;
  logic [8:0]  e_max_reg, e_max_next;
  logic [8:0]  u_min_reg, u_min_next;
  logic [7:0]  d_u_reg, d_u_next;
  logic [7:0]  d_e_reg, d_e_next;
  logic        clr_reg, clr_next;
  logic        tick_start;

  // Slot views padded to 8 entries; absent slots read as dead so the scan ignores them.
  logic [8:0] unit_pos_arr    [8];
  logic [7:0] unit_dmg_arr    [8];
  logic       unit_alive_arr  [8];
  logic [8:0] enemy_pos_arr   [8];
  logic [7:0] enemy_dmg_arr   [8];
  logic       enemy_alive_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NUM_UNITS) begin : g_unit
        assign unit_pos_arr[gi]   = unitPos[9*gi +: 9];
        assign unit_dmg_arr[gi]   = unitDamage[8*gi +: 8];
        assign unit_alive_arr[gi] = ~unitDead[gi];
      end else begin : g_no_unit
        assign unit_pos_arr[gi]   = 9'd0;
        assign unit_dmg_arr[gi]   = 8'd0;
        assign unit_alive_arr[gi] = 1'b0;
      end
      if (gi < NUM_ENEMIES) begin : g_enemy
        assign enemy_pos_arr[gi]   = enemyPos[9*gi +: 9];
        assign enemy_dmg_arr[gi]   = enemyDamage[8*gi +: 8];
        assign enemy_alive_arr[gi] = ~enemyDead[gi];
      end else begin : g_no_enemy
        assign enemy_pos_arr[gi]   = 9'd0;
        assign enemy_dmg_arr[gi]   = 8'd0;
        assign enemy_alive_arr[gi] = 1'b0;
      end
    end
  endgenerate

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign tick_start = !pause && (tick_count_reg == TICK_LAST);
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count_reg <= 24'd0;
    end else if (!pause) begin
      tick_count_reg <= (tick_count_reg == TICK_LAST) ? 24'd0 : tick_count_reg + 24'd1;
    end
  end

  // Strict compares so ties keep the value already accumulated.
  always_comb begin
    e_max_next = e_max_reg;
    u_min_next = u_min_reg;
    d_u_next   = d_u_reg;
    d_e_next   = d_e_reg;
    clr_next   = clr_reg;
    if (enemy_alive_arr[idx_reg]) begin
      if (enemy_pos_arr[idx_reg] > e_max_reg) e_max_next = enemy_pos_arr[idx_reg];
      d_u_next = sat8(d_u_reg, enemy_dmg_arr[idx_reg]);
    end
    if (unit_alive_arr[idx_reg]) begin
      if (unit_pos_arr[idx_reg] < u_min_reg) u_min_next = unit_pos_arr[idx_reg];
      d_e_next = sat8(d_e_reg, unit_dmg_arr[idx_reg]);
      if (unit_pos_arr[idx_reg] > SPAWN_LIMIT) clr_next = 1'b0;
    end
  end

  // Results load at the edge closing the last scan slot, so they appear with damageSCEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= 3'd0;
      e_max_reg       <= 9'd0;
      u_min_reg       <= 9'h1FF;
      d_u_reg         <= 8'd0;
      d_e_reg         <= 8'd0;
      clr_reg         <= 1'b1;
      enemyFront      <= 9'd0;
      unitFront       <= 9'h1FF;
      damageToUnits   <= 8'd0;
      damageToEnemies <= 8'd0;
      canSpawn        <= 1'b1;
      damageSCEN      <= 1'b0;
      moveSCEN        <= 1'b0;
    end else begin
      damageSCEN <= 1'b0;
      moveSCEN   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick_start) begin
            state_reg <= SCAN;
            idx_reg   <= 3'd0;
            e_max_reg <= 9'd0;
            u_min_reg <= 9'h1FF;
            d_u_reg   <= 8'd0;
            d_e_reg   <= 8'd0;
            clr_reg   <= 1'b1;
          end
        end
        SCAN: begin
          e_max_reg <= e_max_next;
          u_min_reg <= u_min_next;
          d_u_reg   <= d_u_next;
          d_e_reg   <= d_e_next;
          clr_reg   <= clr_next;
          if (idx_reg == LAST_IDX) begin
            state_reg       <= APPLY;
            enemyFront      <= e_max_next;
            unitFront       <= u_min_next;
            damageToUnits   <= d_u_next;
            damageToEnemies <= d_e_next;
            canSpawn        <= clr_next;
            damageSCEN      <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 3'd1;
          end
        end
        APPLY: begin
          moveSCEN  <= 1'b1;
          state_reg <= MOVE;
        end
        MOVE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_battle_front_calc.sv
// Directed bench for battle_front_calc with a 16-cycle tick and 4 unit / 4 enemy slots.
module tb_battle_front_calc;

  localparam int          L  = 4;
  localparam logic [23:0] TC = 24'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic [35:0] unitPos = '0;
  logic [31:0] unitDamage = '0;
  logic [3:0]  unitDead = 4'hF;
  logic [35:0] enemyPos = '0;
  logic [31:0] enemyDamage = '0;
  logic [3:0]  enemyDead = 4'hF;
  logic [8:0]  enemyFront, unitFront;
  logic [7:0]  damageToUnits, damageToEnemies;
  logic        damageSCEN, moveSCEN, canSpawn, busy;

  int errors = 0;
  int checks = 0;
  int strobe_overlap = 0;
  int tick_outside_idle = 0;
  int pause_strobes = 0;
  int n;

  battle_front_calc #(
    .NUM_UNITS(4), .NUM_ENEMIES(4), .TICK_CYCLES(TC), .SPAWN_GAP(9'd32)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .unitPos(unitPos), .unitDamage(unitDamage), .unitDead(unitDead),
    .enemyPos(enemyPos), .enemyDamage(enemyDamage), .enemyDead(enemyDead),
    .enemyFront(enemyFront), .unitFront(unitFront),
    .damageToUnits(damageToUnits), .damageToEnemies(damageToEnemies),
    .damageSCEN(damageSCEN), .moveSCEN(moveSCEN), .canSpawn(canSpawn), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && damageSCEN && moveSCEN) strobe_overlap++;
    if (dut.tick_start && busy) tick_outside_idle++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 2ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Returns edges until damageSCEN is seen, or -1 if the bound expires.
  task automatic wait_damage(input int max_cycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk); #1;
      if (damageSCEN) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic wait_busy(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        seen = 1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_outputs(input string tag, input logic [8:0] ef, input logic [8:0] uf,
                               input logic [7:0] du, input logic [7:0] de, input logic cs);
    check({tag, "_enemyFront"}, 32'(enemyFront), 32'(ef));
    check({tag, "_unitFront"}, 32'(unitFront), 32'(uf));
    check({tag, "_damageToUnits"}, 32'(damageToUnits), 32'(du));
    check({tag, "_damageToEnemies"}, 32'(damageToEnemies), 32'(de));
    check({tag, "_canSpawn"}, 32'(canSpawn), 32'(cs));
  endtask

  // Advances from the APPLY cycle into MOVE and checks the second strobe.
  task automatic step_move(input string tag);
    @(posedge clk); #1;
    check({tag, "_moveSCEN"}, 32'(moveSCEN), 32'd1);
    check({tag, "_damageSCEN_low"}, 32'(damageSCEN), 32'd0);
  endtask

  initial begin
    // Reset held three cycles, everything dead.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 9'd0, 9'h1FF, 8'd0, 8'd0, 1'b1);
    check("reset_damageSCEN", 32'(damageSCEN), 32'd0);
    check("reset_moveSCEN", 32'(moveSCEN), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // First tick: counter reaches 15 at cycle 15, APPLY L+1 later.
    wait_damage(40, n);
    check("first_damage_latency", 32'(n), 32'd20);
    check_outputs("all_dead", 9'd0, 9'h1FF, 8'd0, 8'd0, 1'b1);
    step_move("all_dead");

    // Enemies: slot0..3 = 100,40,250,7 with slot2 dead, 32 damage each.
    enemyPos    = {9'd7, 9'd250, 9'd40, 9'd100};
    enemyDead   = 4'b0100;
    enemyDamage = {4{8'd32}};
    wait_damage(40, n);
    check("tick_period", 32'(n), 32'd15);
    check_outputs("enemies", 9'd100, 9'h1FF, 8'd96, 8'd0, 1'b1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("hold", 9'd100, 9'h1FF, 8'd96, 8'd0, 1'b1);

    // Units: slot0..3 pos 300,511,200,260 and damage 80,80,40,10 hex, enemies dead.
    enemyDead  = 4'hF;
    unitDead   = 4'h0;
    unitPos    = {9'd260, 9'd200, 9'd511, 9'd300};
    unitDamage = {8'h10, 8'h40, 8'h80, 8'h80};
    wait_damage(40, n);
    check_outputs("units_511", 9'd0, 9'd200, 8'd0, 8'hFF, 1'b0);
    step_move("units_511");

    unitPos[17:9] = 9'd479;
    wait_damage(40, n);
    check_outputs("units_479", 9'd0, 9'd200, 8'd0, 8'hFF, 1'b1);
    step_move("units_479");

    unitPos[17:9] = 9'd480;
    wait_damage(40, n);
    check_outputs("units_480", 9'd0, 9'd200, 8'd0, 8'hFF, 1'b0);
    step_move("units_480");

    // In MOVE the counter is 5; five more edges bring it to 10, then freeze 50 cycles.
    enemyDead = 4'b0100;
    repeat (5) @(posedge clk);
    #1;
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (damageSCEN || moveSCEN) pause_strobes++;
    end
    pause = 1'b0;
    check("pause_strobes", 32'(pause_strobes), 32'd0);
    wait_damage(40, n);
    check("pause_delay", 32'(n + 55), 32'd65);
    check_outputs("both", 9'd100, 9'd200, 8'd96, 8'hFF, 1'b0);
    step_move("both");

    // Pause raised during SCAN: the scan must still finish with both strobes.
    wait_busy("scan_start_seen");
    pause = 1'b1;
    wait_damage(10, n);
    check("pause_in_scan_latency", 32'(n), 32'(L));
    step_move("pause_in_scan");
    pause = 1'b0;

    // Reset in the last SCAN cycle aborts the tick.
    wait_busy("scan_start_seen2");
    repeat (L - 1) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_damageSCEN", 32'(damageSCEN), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check_outputs("abort", 9'd0, 9'h1FF, 8'd0, 8'd0, 1'b1);
    @(posedge clk); #1;
    check("abort_moveSCEN", 32'(moveSCEN), 32'd0);
    wait_damage(40, n);
    // One edge already consumed above, so the full TICK_CYCLES+L count is n+1.
    check("post_reset_latency", 32'(n + 1), 32'(TC) + 32'(L));
    check_outputs("post_reset", 9'd100, 9'd200, 8'd96, 8'hFF, 1'b0);
    step_move("post_reset");

    check("strobe_overlap", 32'(strobe_overlap), 32'd0);
    check("tick_outside_idle", 32'(tick_outside_idle), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
